// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and shared-ALU signals of the two-port ALU arbiter
interface alu_arbiter_if #(parameter int WIDTH = 32);
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_sel, req1_sel;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic rsp_err;
  logic [WIDTH-1:0] alu_a, alu_b, alu_salida;
  logic [2:0] alu_sel;
  logic alu_en;
  logic [15:0] ops_done;
  modport slave (
    input req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sel, req1_sel,
    input rsp0_ready, rsp1_ready, alu_salida,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    output alu_a, alu_b, alu_sel, alu_en, ops_done
  );
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sel, req1_sel,
    output rsp0_ready, rsp1_ready, alu_salida,
    input req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    input alu_a, alu_b, alu_sel, alu_en, ops_done
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external combinational ALU between two requesters
module alu_arbiter #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] a, b, data;
  logic [2:0] sel, in_sel;
  logic owner, last, err, g0, g1, acc, inv, done;
  logic [15:0] ops;
  // last=1 means req1 was granted most recently, so req0 wins a tie
  always_comb begin
    g0 = state == IDLE && !rst && bus.req0_valid && (!bus.req1_valid || last);
    g1 = state == IDLE && !rst && bus.req1_valid && (!bus.req0_valid || !last);
    acc = g0 | g1;
    in_sel = g1 ? bus.req1_sel : bus.req0_sel;
    inv = in_sel == 3'b101 || in_sel == 3'b110;
    done = state == RESP && (owner ? bus.rsp1_ready : bus.rsp0_ready);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    if (state == IDLE && acc) nxt = inv ? RESP : EXEC;
    if (state == EXEC) nxt = RESP;
    if (done) nxt = IDLE;
  end
  always_comb begin
    bus.req0_ready = g0;
    bus.req1_ready = g1;
    bus.rsp0_valid = state == RESP && !owner;
    bus.rsp1_valid = state == RESP && owner;
    bus.alu_en = state == EXEC;
    bus.alu_a = a;
    bus.alu_b = b;
    bus.alu_sel = sel;
    bus.rsp_data = data;
    bus.rsp_err = err;
    bus.ops_done = ops;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      sel <= '0;
      data <= '0;
      err <= 1'b0;
      owner <= 1'b0;
      last <= 1'b1;
      ops <= '0;
    end else begin
      if (acc) begin
        a <= g1 ? bus.req1_a : bus.req0_a;
        b <= g1 ? bus.req1_b : bus.req0_b;
        sel <= in_sel;
        owner <= g1;
        last <= g1;
        data <= '0;
        err <= inv;
      end
      if (state == EXEC) begin
        data <= bus.alu_salida;
        err <= 1'b0;
      end
      if (done) ops <= ops + 16'd1;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random and directed checks of alu_arbiter against a transaction-timeline model
module tb_alu_arbiter;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  function automatic logic [W-1:0] ref_op(logic [W-1:0] x, logic [W-1:0] y, logic [2:0] s);
    case (s)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x + y;
      3'd3: return x - y;
      3'd4: return ~(x & y);
      3'd7: return x * y;
      default: return '0;
    endcase
  endfunction
  alu_arbiter_if #(.WIDTH(W)) bus();
  alu_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.alu_salida = bus.alu_en ? ref_op(bus.alu_a, bus.alu_b, bus.alu_sel) : '0;
  int total = 0, bad = 0, cyc = 0, rsp_cyc = -1, en_cyc = -1, grant = -1, en_cnt = 0;
  bit busy = 0, last = 1, owner = 0, exp_err = 0, serr0 = 0, serr1 = 0;
  logic [W-1:0] ea, eb, exp_data, seen0, seen1;
  logic [2:0] es;
  logic [15:0] ops = '0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  task automatic tick();
    bit g0, g1, rv;
    @(negedge clk);
    grant = -1;
    g0 = !rst && !busy && bus.req0_valid && (!bus.req1_valid || last);
    g1 = !rst && !busy && bus.req1_valid && (!bus.req0_valid || !last);
    chk("req0_ready", bus.req0_ready, g0);
    chk("req1_ready", bus.req1_ready, g1);
    rv = busy && cyc >= rsp_cyc;
    chk("rsp0_valid", bus.rsp0_valid, rv && !owner);
    chk("rsp1_valid", bus.rsp1_valid, rv && owner);
    chk("alu_en", bus.alu_en, busy && cyc == en_cyc);
    if (bus.alu_en) en_cnt++;
    if (busy && cyc == en_cyc) begin
      chk("alu_a", bus.alu_a, ea);
      chk("alu_b", bus.alu_b, eb);
      chk("alu_sel", bus.alu_sel, es);
    end
    if (rv) begin
      chk("rsp_data", bus.rsp_data, exp_data);
      chk("rsp_err", bus.rsp_err, exp_err);
      if (owner) begin seen1 = bus.rsp_data; serr1 = bus.rsp_err; end
      else begin seen0 = bus.rsp_data; serr0 = bus.rsp_err; end
    end
    chk("ops_done", bus.ops_done, ops);
    if (rst) begin
      busy = 0; last = 1; ops = '0;
    end else if (rv && (owner ? bus.rsp1_ready : bus.rsp0_ready)) begin
      busy = 0; ops++;
    end else if (g0 || g1) begin
      owner = g1; last = g1; grant = int'(g1); busy = 1;
      ea = g1 ? bus.req1_a : bus.req0_a;
      eb = g1 ? bus.req1_b : bus.req0_b;
      es = g1 ? bus.req1_sel : bus.req0_sel;
      exp_err = es == 3'd5 || es == 3'd6;
      exp_data = exp_err ? '0 : ref_op(ea, eb, es);
      rsp_cyc = cyc + (exp_err ? 1 : 2);
      en_cyc = exp_err ? -1 : cyc + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (g0) bus.req0_valid = 1'b0;
    if (g1) bus.req1_valid = 1'b0;
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_alu_en"}, bus.alu_en, 0);
    chk({tag, "_rsp0_valid"}, bus.rsp0_valid, 0);
    chk({tag, "_rsp1_valid"}, bus.rsp1_valid, 0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_alu_a"}, bus.alu_a, 0);
    chk({tag, "_alu_b"}, bus.alu_b, 0);
    chk({tag, "_alu_sel"}, bus.alu_sel, 0);
    chk({tag, "_ops_done"}, bus.ops_done, 0);
  endtask
  task automatic do_reset(int n);
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask
  task automatic set_req(int n, logic [W-1:0] x, logic [W-1:0] y, logic [2:0] s);
    if (n == 0) begin bus.req0_a = x; bus.req0_b = y; bus.req0_sel = s; bus.req0_valid = 1'b1; end
    else begin bus.req1_a = x; bus.req1_b = y; bus.req1_sel = s; bus.req1_valid = 1'b1; end
  endtask
  initial begin
    bit got;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);
    chk_zero("v1");
    repeat (3) tick();
    chk_zero("v1_idle");
    set_req(0, 8, 16, 3'b010);
    bus.rsp0_ready = 1'b1;
    en_cnt = 0;
    tick();
    chk("v2_grant", grant, 0);
    repeat (3) tick();
    chk("v2_data", seen0, 24);
    chk("v2_err", serr0, 0);
    chk("v2_en_cnt", en_cnt, 1);
    chk("v2_ops", bus.ops_done, 1);
    do_reset(2);
    set_req(0, 10, 24, 3'b111);
    set_req(1, 6, 12, 3'b011);
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    tick();
    chk("v3_first", grant, 0);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      got = grant == 1;
    end
    chk("v3_second", got, 1);
    repeat (3) tick();
    chk("v3_data0", seen0, 240);
    chk("v3_data1", seen1, 32'hFFFF_FFFA);
    set_req(0, 3, 4, 3'b001);
    set_req(1, 5, 6, 3'b000);
    tick();
    chk("v3_third", grant, 0);
    repeat (8) tick();
    set_req(1, 84, 36, 3'b101);
    en_cnt = 0;
    tick();
    chk("v4_grant", grant, 1);
    repeat (3) tick();
    chk("v4_err", serr1, 1);
    chk("v4_data", seen1, 0);
    chk("v4_en_cnt", en_cnt, 0);
    set_req(0, 4201, 6669, 3'b000);
    set_req(1, 3, 5, 3'b001);
    bus.rsp0_ready = 1'b0;
    tick();
    chk("v5_grant", grant, 0);
    tick();
    repeat (5) begin
      tick();
      chk("v5_hold", bus.rsp_data, 4105);
      chk("v5_req1_blocked", bus.req1_ready, 0);
    end
    bus.rsp0_ready = 1'b1;
    tick();
    tick();
    chk("v5_next", grant, 1);
    repeat (3) tick();
    do_reset(2);
    set_req(0, 2524, 1, 3'b111);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("v6");
    chk("v6_ready0", bus.req0_ready, 0);
    repeat (2) tick();
    for (int i = 0; i < 2000; i++) begin
      if (!bus.req0_valid && $urandom_range(3) == 0)
        set_req(0, $urandom_range(1) ? $urandom : $urandom_range(255), $urandom_range(1) ? $urandom : $urandom_range(255), 3'($urandom_range(7)));
      else if (bus.req0_valid && $urandom_range(15) == 0) bus.req0_valid = 1'b0;
      if (!bus.req1_valid && $urandom_range(3) == 0)
        set_req(1, $urandom_range(1) ? $urandom : $urandom_range(255), $urandom_range(1) ? $urandom : $urandom_range(255), 3'($urandom_range(7)));
      else if (bus.req1_valid && $urandom_range(15) == 0) bus.req1_valid = 1'b0;
      bus.rsp0_ready = 1'($urandom_range(1));
      bus.rsp1_ready = 1'($urandom_range(1));
      rst = $urandom_range(199) == 0;
      tick();
    end
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
